// File: rtl/seq_det_feed_ctrl_pkg.sv
// Shared types for the seq_det word feeder: FSM state enum and index-width helper.
// No ports; imported by the feeder RTL and by seq_det benches.
package seq_det_feed_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SHIFT,
    ST_DRAIN,
    ST_REPORT
  } state_e;

  // Width of a counter holding 0..n-1, never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_det_feed_ctrl_if.sv
// Word-in / report-out handshake bundle for seq_det_feed_ctrl.
// s_valid/s_ready/s_data: word stream; m_valid/m_ready/m_hits/m_any/m_sat: per-word report.
interface seq_det_feed_ctrl_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);

  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [CNT_W-1:0]  m_hits;
  logic              m_any;
  logic              m_sat;

  modport master (
    output s_valid,
    output s_data,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_hits,
    input  m_any,
    input  m_sat
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_hits,
    output m_any,
    output m_sat
  );

endinterface

// File: rtl/seq_det_feed_ctrl_shift_out.sv
// seq_shift_out: parallel-in serial-out shifter, MSB first.
// Ports: clk, nrst, load_i, shift_i, data_i[WORD_W]; nxt_msb_o = MSB the register will hold next.
module seq_shift_out #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              nxt_msb_o
);

  logic [WORD_W-1:0] sr_q;
  logic [WORD_W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = sr_q << 1;
    end
  end

  // Look-ahead MSB lets the caller register det_in without a cycle of skew.
  assign nxt_msb_o = sr_d[WORD_W-1];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/seq_det_feed_ctrl.sv
// seq_det_feed_ctrl: shifts words MSB-first into an external seq_det and reports per-word hits.
// Ports: clk, nrst (sync, active low), bus (slave), det_in, det_out, det_clr_n; macro SEQ_DET_WORD_CLR_EN.
module seq_det_feed_ctrl
  import seq_det_feed_ctrl_pkg::*;
#(
  parameter int   WORD_W   = 8,
  parameter int   CNT_W    = 4,
  parameter int   DET_LAT  = 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                      clk,
  input  logic                      nrst,
  seq_det_feed_ctrl_if.slave        bus,
  output logic                      det_in,
  input  logic                      det_out,
  output logic                      det_clr_n
);

  localparam int IW = idx_w(WORD_W);
  localparam int DW = idx_w(DET_LAT);
  localparam logic [IW-1:0] LAST = IW'(WORD_W - 1);
  localparam logic [DW-1:0] DLAST = DW'(DET_LAT - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e             state_q;
  state_e             state_d;
  logic [IW-1:0]      idx_q;
  logic [IW-1:0]      idx_d;
  logic [DW-1:0]      drn_q;
  logic [DW-1:0]      drn_d;
  logic [DET_LAT-1:0] vp_q;
  logic [DET_LAT-1:0] vp_d;
  logic [DET_LAT:0]   vp_ext;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               sat_q;
  logic               sat_d;
  logic               any_q;
  logic               any_d;
  logic               s_ready_q;
  logic               s_ready_d;
  logic               m_valid_q;
  logic               m_valid_d;
  logic               det_in_q;
  logic               det_in_d;
  logic               load;
  logic               shift;
  logic               clr_cnt;
  logic               nxt_msb;
  logic               hit;

  seq_shift_out #(
    .WORD_W (WORD_W)
  ) u_sr (
    .clk       (clk),
    .nrst      (nrst),
    .load_i    (load),
    .shift_i   (shift),
    .data_i    (bus.s_data),
    .nxt_msb_o (nxt_msb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drn_d   = drn_q;
    load    = 1'b0;
    shift   = 1'b0;
    clr_cnt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.s_valid && s_ready_q) begin
          load    = 1'b1;
          clr_cnt = 1'b1;
          idx_d   = '0;
`ifdef SEQ_DET_WORD_CLR_EN
          state_d = ST_CLR;
`else
          state_d = ST_SHIFT;
`endif
        end
      end
      ST_CLR: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift = 1'b1;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          state_d = ST_DRAIN;
          drn_d   = '0;
        end
      end
      ST_DRAIN: begin
        drn_d = drn_q + DW'(1);
        if (drn_q == DLAST) begin
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (m_valid_q && bus.m_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Outputs are registered from the next state so they line up with it.
    s_ready_d = (state_d == ST_IDLE);
    m_valid_d = (state_d == ST_REPORT);
    det_in_d  = (state_d == ST_SHIFT) ? nxt_msb : IDLE_BIT;
  end

  // Tag each detector sample with whether a word bit produced it.
  always_comb begin
    vp_ext = {vp_q, (state_q == ST_SHIFT)};
    vp_d   = vp_ext[DET_LAT-1:0];
  end

  assign hit = vp_q[DET_LAT-1] && det_out;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_cnt) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (hit) begin
      if (cnt_q == CMAX) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    any_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      drn_q     <= '0;
      vp_q      <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      any_q     <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      det_in_q  <= IDLE_BIT;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      drn_q     <= drn_d;
      vp_q      <= vp_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      any_q     <= any_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      det_in_q  <= det_in_d;
    end
  end

`ifdef SEQ_DET_WORD_CLR_EN
  logic clr_n_q;

  // Low for the single CLR cycle, right before the first word bit.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      clr_n_q <= 1'b1;
    end else begin
      clr_n_q <= (state_d != ST_CLR);
    end
  end

  assign det_clr_n = clr_n_q;
`else
  assign det_clr_n = 1'b1;
`endif

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_hits  = cnt_q;
  assign bus.m_any   = any_q;
  assign bus.m_sat   = sat_q;
  assign det_in      = det_in_q;

endmodule

// File: tb/tb_seq_det_feed_ctrl.sv
// Bench for seq_det_feed_ctrl with a behavioural overlapping "1011" detector (latency 1).
// Table-driven words plus reset, period, saturation and mid-word reset sequences.
module tb_seq_det_feed_ctrl;

  localparam int WW = 8;
  localparam int DL = 1;
`ifdef SEQ_DET_WORD_CLR_EN
  localparam int CLRX = 1;
`else
  localparam int CLRX = 0;
`endif

  typedef struct {
    logic [7:0] w;
    logic [3:0] hits;
    logic       any;
    logic       sat;
    int         hold;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst;
  logic din1, dout1, clrn1;
  logic din2, dout2, clrn2;
  logic [2:0] h1, h2;

  int n_cmp = 0;
  int n_err = 0;

  seq_det_feed_ctrl_if #(.WORD_W(8), .CNT_W(4)) bus ();
  seq_det_feed_ctrl_if #(.WORD_W(8), .CNT_W(1)) bus2 ();

  seq_det_feed_ctrl #(
    .WORD_W(8), .CNT_W(4), .DET_LAT(1), .IDLE_BIT(1'b0)
  ) dut (
    .clk(clk), .nrst(nrst), .bus(bus),
    .det_in(din1), .det_out(dout1), .det_clr_n(clrn1)
  );

  seq_det_feed_ctrl #(
    .WORD_W(8), .CNT_W(1), .DET_LAT(1), .IDLE_BIT(1'b0)
  ) dut2 (
    .clk(clk), .nrst(nrst), .bus(bus2),
    .det_in(din2), .det_out(dout2), .det_clr_n(clrn2)
  );

  // External overlapping "1011" detectors, output one cycle after the last bit.
  always_ff @(posedge clk) begin
    if (!(nrst && clrn1)) begin
      h1 <= 3'b000;
      dout1 <= 1'b0;
    end else begin
      h1 <= {h1[1:0], din1};
      dout1 <= (h1 == 3'b101) && din1;
    end
  end

  always_ff @(posedge clk) begin
    if (!(nrst && clrn2)) begin
      h2 <= 3'b000;
      dout2 <= 1'b0;
    end else begin
      h2 <= {h2[1:0], din2};
      dout2 <= (h2 == 3'b101) && din2;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", 32'(n < 40), 1);
  endtask

  task automatic do_word(input vec_t v, input int id);
    logic        din_a [30];
    logic [31:0] clrm;
    logic [7:0]  got;
    logic        bad;
    logic        done;
    int          k;
    wait_ready();
    bus.m_ready = (v.hold == 0);
    bus.s_valid = 1'b1;
    bus.s_data  = v.w;
    @(negedge clk);
    bus.s_valid = 1'b0;
    k = 0;
    done = 1'b0;
    clrm = '0;
    while (!done && k < 30) begin
      din_a[k] = din1;
      if (clrn1 !== 1'b1) clrm[k] = 1'b1;
      if (bus.m_valid === 1'b1) done = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk($sformatf("w%0d_lat", id), k, WW + DL + CLRX);
    for (int i = 0; i < 8; i++) got[7-i] = din_a[CLRX+i];
    chk($sformatf("w%0d_bits", id), got, v.w);
    chk($sformatf("w%0d_drain", id), din_a[CLRX+8], 0);
    chk($sformatf("w%0d_clrn", id), clrm, CLRX);
    chk($sformatf("w%0d_hits", id), bus.m_hits, v.hits);
    chk($sformatf("w%0d_any", id), bus.m_any, v.any);
    chk($sformatf("w%0d_sat", id), bus.m_sat, v.sat);
    if (v.hold > 0) begin
      bad = 1'b0;
      for (int i = 0; i < v.hold; i++) begin
        @(negedge clk);
        if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0 ||
            bus.m_hits !== v.hits) bad = 1'b1;
      end
      chk($sformatf("w%0d_hold", id), bad, 0);
      bus.m_ready = 1'b1;
    end
    @(negedge clk);
    chk($sformatf("w%0d_mv_drop", id), bus.m_valid, 0);
    chk($sformatf("w%0d_rdy_back", id), bus.s_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [7];
    int   n, acc, t0, per;
    logic seen;

    vt[0] = '{8'hB0, 4'd1, 1'b1, 1'b0, 0};
    vt[1] = '{8'hDB, 4'd2, 1'b1, 1'b0, 0};
    vt[2] = '{8'h00, 4'd0, 1'b0, 1'b0, 5};
    vt[3] = '{8'hFF, 4'd0, 1'b0, 1'b0, 0};
    vt[4] = '{8'hBB, 4'd2, 1'b1, 1'b0, 0};
    vt[5] = '{8'h5A, 4'd1, 1'b1, 1'b0, 0};
    vt[6] = '{8'hAB, 4'd1, 1'b1, 1'b0, 2};

    nrst = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    bus.m_ready = 1'b0;
    bus2.s_valid = 1'b0;
    bus2.s_data = 8'h00;
    bus2.m_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_det_in", din1, 0);
    chk("rst_clr_n", clrn1, 1);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_hits", bus.m_hits, 0);
    chk("rst_m_any", bus.m_any, 0);
    chk("rst_m_sat", bus.m_sat, 0);
    nrst = 1'b1;
    @(negedge clk);
    chk("rel_s_ready", bus.s_ready, 1);

    for (int i = 0; i < 7; i++) do_word(vt[i], i);

    // Back-to-back: s_valid held high across two words.
    wait_ready();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 8'hB0;
    n = 0;
    acc = 0;
    t0 = 0;
    per = 0;
    while (acc < 2 && n < 60) begin
      if (bus.s_ready === 1'b1) begin
        acc++;
        if (acc == 1) t0 = n;
        else per = n - t0;
      end
      @(negedge clk);
      n++;
    end
    bus.s_valid = 1'b0;
    chk("b2b_period", per, WW + DL + 2 + CLRX);
    wait_ready();

    // One-bit counter saturates on the second hit.
    bus2.m_ready = 1'b1;
    bus2.s_valid = 1'b1;
    bus2.s_data = 8'hDB;
    @(negedge clk);
    bus2.s_valid = 1'b0;
    n = 0;
    while (bus2.m_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("c1_done", 32'(n < 40), 1);
    chk("c1_hits", bus2.m_hits, 1);
    chk("c1_any", bus2.m_any, 1);
    chk("c1_sat", bus2.m_sat, 1);
    @(negedge clk);

    // Reset at bit 5 of 1011_1011: one hit already counted, then dropped.
    wait_ready();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 8'hBB;
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (CLRX + 5) @(negedge clk);
    chk("mid_bit5", din1, 0);
    chk("mid_pre_hits", bus.m_hits, 1);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    chk("mid_hits_clr", bus.m_hits, 0);
    chk("mid_rdy_low", bus.s_ready, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.m_valid !== 1'b0) seen = 1'b1;
    end
    chk("mid_no_mvalid", seen, 0);
    chk("mid_rdy_back", bus.s_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
